// File: rtl/banco_registradores_pkg.sv
// Shared definitions for the decode-stage register file: default widths,
// MIPS register-name constants and the r0 hard-wiring helper.
package banco_registradores_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int ADDR_W_DEF = 5;

    localparam logic [4:0] REG_ZERO = 5'd0;
    localparam logic [4:0] REG_SP   = 5'd29;
    localparam logic [4:0] REG_RA   = 5'd31;

    // True when an access to this address must be treated as the hard-wired r0.
    function automatic logic is_hard_zero(input int zero_reg, input logic addr_is_zero);
        return (zero_reg != 0) && addr_is_zero;
    endfunction

endpackage

// File: rtl/banco_read_port.sv
// One read port of the register file: address mux, r0 forcing, write bypass
// and the pending-write (busy) flag seen by issue logic.
module banco_read_port
    import banco_registradores_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int BYPASS   = 1,
    parameter int ZERO_REG = 1
) (
    input  logic [DATA_W-1:0]       regs [1<<ADDR_W],
    input  logic [(1<<ADDR_W)-1:0]  busy,
    input  logic [ADDR_W-1:0]       addr,
    input  logic                    wr_acc,
    input  logic [ADDR_W-1:0]       wr_addr,
    input  logic [DATA_W-1:0]       wr_data,
    output logic [DATA_W-1:0]       data,
    output logic                    data_busy
);

    // wr_acc already excludes writes dropped on r0, so a hit is always a real write.
    logic hit;
    assign hit = (BYPASS != 0) && wr_acc && (wr_addr == addr);

    // Select stored value, override with the in-flight write, then force r0 to zero.
    always_comb begin
        data = regs[addr];
        if (hit) begin
            data = wr_data;
        end
        if (is_hard_zero(ZERO_REG, addr == '0)) begin
            data = '0;
        end
        data_busy = busy[addr] && !hit;
    end

endmodule

// File: rtl/banco_registradores.sv
// Decode-stage register file: NUM_RD combinational read ports, one writeback
// write port, optional write-to-read bypass and a per-register busy scoreboard.
// Writes and reservations are single-cycle strobes sampled on the rising edge;
// there is no handshake, the port accepts every strobe presented to it.
// A reservation and a write to the same register in one cycle leave it busy:
// the reservation belongs to a newer instruction than the one writing back.
module banco_registradores
    import banco_registradores_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int NUM_RD   = 2,
    parameter int BYPASS   = 1,
    parameter int ZERO_REG = 1
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [NUM_RD*ADDR_W-1:0]   rd_addr,
    output logic [NUM_RD*DATA_W-1:0]   rd_data,
    output logic [NUM_RD-1:0]          rd_busy,
    input  logic                       wr_en,
    input  logic [ADDR_W-1:0]          wr_addr,
    input  logic [DATA_W-1:0]          wr_data,
    input  logic                       resv_en,
    input  logic [ADDR_W-1:0]          resv_addr,
    output logic [(1<<ADDR_W)-1:0]     busy_vec
);

    localparam int NREGS = 1 << ADDR_W;

    logic [DATA_W-1:0] regs [NREGS];
    logic [NREGS-1:0]  busy;
    logic [NREGS-1:0]  busy_next;
    logic              wr_acc;
    logic              resv_acc;

    assign wr_acc   = wr_en   && !is_hard_zero(ZERO_REG, wr_addr == '0);
    assign resv_acc = resv_en && !is_hard_zero(ZERO_REG, resv_addr == '0);
    assign busy_vec = busy;

    // Scoreboard update: a write clears, a reservation applied afterwards wins.
    always_comb begin
        busy_next = busy;
        if (wr_acc) begin
            busy_next[wr_addr] = 1'b0;
        end
        if (resv_acc) begin
            busy_next[resv_addr] = 1'b1;
        end
    end

    // Storage and busy bits; reset wipes everything, including pending reservations.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
            busy <= '0;
        end else begin
            if (wr_acc) begin
                regs[wr_addr] <= wr_data;
            end
            busy <= busy_next;
        end
    end

    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
        banco_read_port #(
            .DATA_W   (DATA_W),
            .ADDR_W   (ADDR_W),
            .BYPASS   (BYPASS),
            .ZERO_REG (ZERO_REG)
        ) u_port (
            .regs      (regs),
            .busy      (busy),
            .addr      (rd_addr[k*ADDR_W +: ADDR_W]),
            .wr_acc    (wr_acc),
            .wr_addr   (wr_addr),
            .wr_data   (wr_data),
            .data      (rd_data[k*DATA_W +: DATA_W]),
            .data_busy (rd_busy[k])
        );
    end

endmodule

// File: tb/tb_banco_registradores.sv
// Bench for the register file. Instance A uses the defaults (32-bit, 2 ports,
// bypass, hard-wired r0); instance B is 16-bit, 3 ports, no bypass, ordinary r0.
module tb_banco_registradores;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    // ---------------- instance A ----------------
    logic [9:0]  a_rd_addr;
    logic [63:0] a_rd_data;
    logic [1:0]  a_rd_busy;
    logic        a_wr_en;
    logic [4:0]  a_wr_addr;
    logic [31:0] a_wr_data;
    logic        a_resv_en;
    logic [4:0]  a_resv_addr;
    logic [31:0] a_busy_vec;

    banco_registradores dut_a (
        .clk       (clk),
        .reset     (reset),
        .rd_addr   (a_rd_addr),
        .rd_data   (a_rd_data),
        .rd_busy   (a_rd_busy),
        .wr_en     (a_wr_en),
        .wr_addr   (a_wr_addr),
        .wr_data   (a_wr_data),
        .resv_en   (a_resv_en),
        .resv_addr (a_resv_addr),
        .busy_vec  (a_busy_vec)
    );

    // ---------------- instance B ----------------
    logic [14:0] b_rd_addr;
    logic [47:0] b_rd_data;
    logic [2:0]  b_rd_busy;
    logic        b_wr_en;
    logic [4:0]  b_wr_addr;
    logic [15:0] b_wr_data;
    logic        b_resv_en;
    logic [4:0]  b_resv_addr;
    logic [31:0] b_busy_vec;

    banco_registradores #(
        .DATA_W   (16),
        .ADDR_W   (5),
        .NUM_RD   (3),
        .BYPASS   (0),
        .ZERO_REG (0)
    ) dut_b (
        .clk       (clk),
        .reset     (reset),
        .rd_addr   (b_rd_addr),
        .rd_data   (b_rd_data),
        .rd_busy   (b_rd_busy),
        .wr_en     (b_wr_en),
        .wr_addr   (b_wr_addr),
        .wr_data   (b_wr_data),
        .resv_en   (b_resv_en),
        .resv_addr (b_resv_addr),
        .busy_vec  (b_busy_vec)
    );

    // ---------------- reference model ----------------
    logic [31:0] ma_regs [32];
    logic [31:0] ma_busy;
    logic [15:0] mb_regs [32];
    logic [31:0] mb_busy;

    int checks = 0;
    int errors = 0;

    task automatic model_reset();
        for (int i = 0; i < 32; i++) begin
            ma_regs[i] = '0;
            mb_regs[i] = '0;
        end
        ma_busy = '0;
        mb_busy = '0;
    endtask

    // What A must show on port k: r0 reads zero, a live write is forwarded, else storage.
    function automatic logic [31:0] exp_a_data(int k);
        logic [4:0] ad;
        ad = a_rd_addr[k*5 +: 5];
        if (ad == 5'd0) return 32'd0;
        if (a_wr_en && a_wr_addr == ad) return a_wr_data;
        return ma_regs[ad];
    endfunction

    function automatic logic exp_a_busy(int k);
        logic [4:0] ad;
        ad = a_rd_addr[k*5 +: 5];
        if (ad != 5'd0 && a_wr_en && a_wr_addr == ad) return 1'b0;
        return ma_busy[ad];
    endfunction

    // Apply the edge to the model, using the inputs presented during the cycle.
    task automatic model_edge();
        if (a_wr_en && a_wr_addr != 5'd0) begin
            ma_regs[a_wr_addr] = a_wr_data;
            ma_busy[a_wr_addr] = 1'b0;
        end
        if (a_resv_en && a_resv_addr != 5'd0) ma_busy[a_resv_addr] = 1'b1;
        if (b_wr_en) begin
            mb_regs[b_wr_addr] = b_wr_data;
            mb_busy[b_wr_addr] = 1'b0;
        end
        if (b_resv_en) mb_busy[b_resv_addr] = 1'b1;
    endtask

    // ---------------- scoreboard ----------------
    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("%s a_data%0d", tag, k), {32'd0, a_rd_data[k*32 +: 32]}, {32'd0, exp_a_data(k)});
            chk($sformatf("%s a_busy%0d", tag, k), {63'd0, a_rd_busy[k]}, {63'd0, exp_a_busy(k)});
        end
        chk({tag, " a_busy_vec"}, {32'd0, a_busy_vec}, {32'd0, ma_busy});
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("%s b_data%0d", tag, k), {48'd0, b_rd_data[k*16 +: 16]},
                {48'd0, mb_regs[b_rd_addr[k*5 +: 5]]});
            chk($sformatf("%s b_busy%0d", tag, k), {63'd0, b_rd_busy[k]},
                {63'd0, mb_busy[b_rd_addr[k*5 +: 5]]});
        end
        chk({tag, " b_busy_vec"}, {32'd0, b_busy_vec}, {32'd0, mb_busy});
    endtask

    // ---------------- driver tasks ----------------
    task automatic idle();
        a_wr_en = 1'b0; a_resv_en = 1'b0;
        b_wr_en = 1'b0; b_resv_en = 1'b0;
    endtask

    // Inputs are driven at posedge+1; outputs are checked at the falling edge.
    task automatic settle();
        #4;
    endtask

    task automatic tick();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        reset = 1'b1;
        a_rd_addr = '0; b_rd_addr = '0;
        a_wr_addr = '0; a_wr_data = '0; a_resv_addr = '0;
        b_wr_addr = '0; b_wr_data = '0; b_resv_addr = '0;
        idle();
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        settle();
        check_all("reset");
        @(posedge clk); #1;

        // Arbitrary writes, then an async reset between edges
        for (int i = 1; i < 6; i++) begin
            a_wr_en = 1'b1; a_wr_addr = 5'(i); a_wr_data = 32'h1000 + i;
            b_wr_en = 1'b1; b_wr_addr = 5'(i); b_wr_data = 16'h200 + 16'(i);
            tick();
        end
        idle();
        a_rd_addr = {5'd2, 5'd4}; b_rd_addr = {5'd1, 5'd3, 5'd5};
        settle();
        check_all("pre_reset");
        reset = 1'b1;
        #1;
        model_reset();
        check_all("async_reset");
        chk("reset a_port0 zero", {32'd0, a_rd_data[31:0]}, 64'd0);
        @(posedge clk); #1;
        reset = 1'b0;

        // Write r5, read it on every port next cycle
        a_wr_en = 1'b1; a_wr_addr = 5'd5; a_wr_data = 32'hDEADBEEF;
        b_wr_en = 1'b1; b_wr_addr = 5'd5; b_wr_data = 16'hBEEF;
        tick();
        idle();
        a_rd_addr = {5'd5, 5'd5}; b_rd_addr = {5'd5, 5'd5, 5'd5};
        settle();
        check_all("r5_read");
        chk("r5 a_port0", {32'd0, a_rd_data[31:0]}, 64'hDEADBEEF);
        chk("r5 a_port1", {32'd0, a_rd_data[63:32]}, 64'hDEADBEEF);
        tick();

        // Write r0: dropped on A, stored on B
        a_wr_en = 1'b1; a_wr_addr = 5'd0; a_wr_data = 32'h1234;
        b_wr_en = 1'b1; b_wr_addr = 5'd0; b_wr_data = 16'h1234;
        a_rd_addr = {5'd0, 5'd0}; b_rd_addr = {5'd0, 5'd0, 5'd0};
        settle();
        check_all("r0_write_cycle");
        tick();
        idle();
        settle();
        check_all("r0_read");
        chk("r0 a_port0", {32'd0, a_rd_data[31:0]}, 64'd0);
        chk("r0 b_port0", {48'd0, b_rd_data[15:0]}, 64'h1234);
        tick();

        // Reserve r7 so the bypass cycle also exercises busy masking
        a_resv_en = 1'b1; a_resv_addr = 5'd7;
        b_resv_en = 1'b1; b_resv_addr = 5'd7;
        tick();
        idle();
        a_wr_en = 1'b1; a_wr_addr = 5'd7; a_wr_data = 32'hA5A5A5A5;
        b_wr_en = 1'b1; b_wr_addr = 5'd7; b_wr_data = 16'hA5A5;
        a_rd_addr = {5'd7, 5'd7}; b_rd_addr = {5'd7, 5'd7, 5'd7};
        settle();
        check_all("bypass");
        chk("bypass a_data0", {32'd0, a_rd_data[31:0]}, 64'hA5A5A5A5);
        chk("bypass a_busy0", {63'd0, a_rd_busy[0]}, 64'd0);
        chk("nobypass b_data0", {48'd0, b_rd_data[15:0]}, 64'd0);
        chk("nobypass b_busy0", {63'd0, b_rd_busy[0]}, 64'd1);
        tick();
        idle();

        // Reserve r9, read busy, write clears, then reserve+write same cycle
        a_resv_en = 1'b1; a_resv_addr = 5'd9;
        b_resv_en = 1'b1; b_resv_addr = 5'd9;
        tick();
        idle();
        a_rd_addr = {5'd9, 5'd9}; b_rd_addr = {5'd9, 5'd9, 5'd9};
        settle();
        check_all("r9_busy");
        chk("r9 a_busy1", {63'd0, a_rd_busy[1]}, 64'd1);
        tick();
        a_wr_en = 1'b1; a_wr_addr = 5'd9; a_wr_data = 32'h99;
        b_wr_en = 1'b1; b_wr_addr = 5'd9; b_wr_data = 16'h99;
        tick();
        idle();
        settle();
        check_all("r9_cleared");
        chk("r9 a_busy_vec9", {63'd0, a_busy_vec[9]}, 64'd0);
        tick();
        a_wr_en = 1'b1; a_wr_addr = 5'd9; a_wr_data = 32'h5A5A0009;
        a_resv_en = 1'b1; a_resv_addr = 5'd9;
        b_wr_en = 1'b1; b_wr_addr = 5'd9; b_wr_data = 16'h0909;
        b_resv_en = 1'b1; b_resv_addr = 5'd9;
        tick();
        idle();
        settle();
        check_all("r9_resv_wins");
        chk("r9 a_busy_vec9 set", {63'd0, a_busy_vec[9]}, 64'd1);
        chk("r9 a_data stored", {32'd0, a_rd_data[31:0]}, 64'h5A5A0009);
        tick();

        // Reserve r0: ignored on A, honoured on B; then reserve r3 and reset mid-cycle
        a_resv_en = 1'b1; a_resv_addr = 5'd0;
        b_resv_en = 1'b1; b_resv_addr = 5'd0;
        tick();
        idle();
        settle();
        check_all("r0_resv");
        chk("r0 a_busy_vec0", {63'd0, a_busy_vec[0]}, 64'd0);
        chk("r0 b_busy_vec0", {63'd0, b_busy_vec[0]}, 64'd1);
        a_wr_en = 1'b1; a_wr_addr = 5'd3; a_wr_data = 32'h33;
        tick();
        idle();
        a_resv_en = 1'b1; a_resv_addr = 5'd3;
        b_resv_en = 1'b1; b_resv_addr = 5'd3;
        tick();
        idle();
        a_rd_addr = {5'd3, 5'd3}; b_rd_addr = {5'd3, 5'd3, 5'd3};
        settle();
        check_all("r3_busy");
        reset = 1'b1;
        #1;
        model_reset();
        check_all("r3_async_reset");
        chk("r3 a_busy_vec3", {63'd0, a_busy_vec[3]}, 64'd0);
        chk("r3 a_data", {32'd0, a_rd_data[31:0]}, 64'd0);
        @(posedge clk); #1;
        reset = 1'b0;

        // Random traffic; addresses biased to a small window so collisions are frequent
        for (int n = 0; n < 3000; n++) begin
            a_wr_en = 1'($urandom_range(0, 1));
            a_wr_addr = ($urandom_range(0, 1) != 0) ? 5'($urandom_range(0, 7)) : 5'($urandom);
            a_wr_data = $urandom;
            a_resv_en = 1'($urandom_range(0, 1));
            a_resv_addr = 5'($urandom_range(0, 7));
            a_rd_addr = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
            b_wr_en = 1'($urandom_range(0, 1));
            b_wr_addr = 5'($urandom_range(0, 7));
            b_wr_data = 16'($urandom);
            b_resv_en = 1'($urandom_range(0, 1));
            b_resv_addr = 5'($urandom_range(0, 7));
            b_rd_addr = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 5'($urandom)};
            settle();
            check_all($sformatf("rand%0d", n));
            tick();
        end
        idle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
